// File: rtl/snn_ctrl_pkg.sv
// Shared types and control-register bit positions for the SNN run controller.
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        LOAD,
        STEP,
        WAIT,
        FINISH
    } run_state_t;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 2;
    localparam int CTRL_DONE_BIT  = 3;

endpackage

// File: rtl/snn_run_controller.sv
// Sequences one spiking-network run: clear, then fetch/load/step/wait per timestep
// until the latched simulation time is reached, then raise a sticky done.
module snn_run_controller
    import snn_ctrl_pkg::*;
#(
    parameter int SIM_TIME_WIDTH  = 32,
    parameter int PATTERN_WIDTH   = 32,
    parameter int STEP_ADDR_WIDTH = 8,
    parameter int BATCH_SEL_WIDTH = 6
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [SIM_TIME_WIDTH-1:0]                  sim_time,
    input  logic [BATCH_SEL_WIDTH-1:0]                 batch_sel,
    output logic                                       pat_mem_rd_en,
    output logic [BATCH_SEL_WIDTH+STEP_ADDR_WIDTH-1:0] pat_mem_addr,
    input  logic [PATTERN_WIDTH-1:0]                   pat_mem_rdata,
    output logic [PATTERN_WIDTH-1:0]                   spike_in,
    output logic                                       network_rst,
    output logic                                       network_step,
    input  logic                                       network_step_done,
    output logic                                       network_busy,
    output logic                                       done,
    output logic [SIM_TIME_WIDTH-1:0]                  timestep
);

    run_state_t                  state_reg;
    run_state_t                  state_next;
    logic                        start_prev_reg;
    logic [SIM_TIME_WIDTH-1:0]   sim_time_reg;
    logic [BATCH_SEL_WIDTH-1:0]  batch_reg;
    logic [SIM_TIME_WIDTH-1:0]   t_reg;
    logic [PATTERN_WIDTH-1:0]    spike_in_reg;
    logic                        done_reg;
    logic                        start_edge;
    logic [SIM_TIME_WIDTH-1:0]   t_plus1;

    assign start_edge = start & ~start_prev_reg;
    assign t_plus1    = t_reg + {{(SIM_TIME_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_next    = state_reg;
        network_rst   = 1'b0;
        network_step  = 1'b0;
        pat_mem_rd_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge)
                    state_next = (sim_time == '0) ? FINISH : CLEAR;
            end
            CLEAR: begin
                network_rst = 1'b1;
                state_next  = FETCH;
            end
            FETCH: begin
                pat_mem_rd_en = 1'b1;
                state_next    = LOAD;
            end
            LOAD:   state_next = STEP;
            STEP: begin
                network_step = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (network_step_done)
                    state_next = (t_plus1 == sim_time_reg) ? FINISH : FETCH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides every transition out of a busy state.
        if (abort && state_reg != IDLE)
            state_next = IDLE;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            sim_time_reg   <= '0;
            batch_reg      <= '0;
            t_reg          <= '0;
            spike_in_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= start;
            if (state_reg == IDLE && start_edge) begin
                done_reg     <= 1'b0;
                sim_time_reg <= sim_time;
                batch_reg    <= batch_sel;
            end
            if (state_reg == CLEAR)
                t_reg <= '0;
            if (state_reg == LOAD)
                spike_in_reg <= pat_mem_rdata;
            if (state_reg == WAIT && network_step_done && !abort)
                t_reg <= t_plus1;
            if (state_reg == FINISH && !abort)
                done_reg <= 1'b1;
        end
    end

    // Low address bits wrap naturally, so patterns repeat every 2^STEP_ADDR_WIDTH steps.
    assign pat_mem_addr = {batch_reg, t_reg[STEP_ADDR_WIDTH-1:0]};
    assign spike_in     = spike_in_reg;
    assign network_busy = (state_reg != IDLE);
    assign done         = done_reg;
    assign timestep     = t_reg;

endmodule

// File: tb/tb_snn_run_controller.sv
// Directed bench for snn_run_controller with a pattern-memory and network-response model.
module tb_snn_run_controller;

    logic        S_AXI_ACLK = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] sim_time;
    logic [5:0]  batch_sel;
    logic        pat_mem_rd_en;
    logic [13:0] pat_mem_addr;
    logic [31:0] pat_mem_rdata = '0;
    logic [31:0] spike_in;
    logic        network_rst;
    logic        network_step;
    logic        network_step_done;
    logic        network_busy;
    logic        done;
    logic [31:0] timestep;

    logic resp_reg   = 1'b0;
    logic force_done = 1'b0;

    int checks = 0;
    int errors = 0;

    snn_run_controller dut (
        .S_AXI_ACLK        (S_AXI_ACLK),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .sim_time          (sim_time),
        .batch_sel         (batch_sel),
        .pat_mem_rd_en     (pat_mem_rd_en),
        .pat_mem_addr      (pat_mem_addr),
        .pat_mem_rdata     (pat_mem_rdata),
        .spike_in          (spike_in),
        .network_rst       (network_rst),
        .network_step      (network_step),
        .network_step_done (network_step_done),
        .network_busy      (network_busy),
        .done              (done),
        .timestep          (timestep)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    function automatic logic [31:0] pattern(input logic [13:0] a);
        return {a[7:0] + 8'h3C, 2'b10, a, ~a[7:0]};
    endfunction

    // Pattern memory with one-cycle read latency; network answers one cycle after each step.
    always @(posedge S_AXI_ACLK) begin
        if (pat_mem_rd_en) pat_mem_rdata <= pattern(pat_mem_addr);
        resp_reg <= network_step;
    end
    assign network_step_done = resp_reg | force_done;

    task automatic cyc();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // Launches a run (start edge sampled in cycle 0) and gathers what the DUT did until done.
    task automatic run_seq(input int st, input int bt, input int budget,
                           input bit hold, input bit chg, input bit spur,
                           output int n_steps, output int n_rd, output int n_rst,
                           output int done_cyc, output int busy_at_done,
                           output int addr_bad, output int spike_bad,
                           output int wrapped, output int ts);
        logic [5:0]  b6;
        logic [7:0]  k8;
        logic [13:0] exp_addr;
        b6 = bt[5:0];
        n_steps = 0; n_rd = 0; n_rst = 0; done_cyc = -1; busy_at_done = -1;
        addr_bad = 0; spike_bad = 0; wrapped = 0; ts = -1;
        start = 1'b0; abort = 1'b0; force_done = 1'b0;
        cyc();
        sim_time  = st;
        batch_sel = b6;
        start     = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            cyc();
            if (!hold) start = 1'b0;
            if (chg && c == 3) begin
                sim_time  = st + 4;
                batch_sel = b6 + 6'd4;
            end
            force_done = spur && (c <= 4);
            if (pat_mem_rd_en) begin
                k8 = n_rd[7:0];
                exp_addr = {b6, k8};
                if (pat_mem_addr !== exp_addr) addr_bad++;
                if (n_rd > 0 && pat_mem_addr[7:0] == 8'h00) wrapped = 1;
                n_rd++;
            end
            if (network_step) begin
                k8 = n_steps[7:0];
                exp_addr = {b6, k8};
                if (spike_in !== pattern(exp_addr)) spike_bad++;
                n_steps++;
            end
            if (network_rst) n_rst++;
            if (done) begin
                done_cyc     = c;
                busy_at_done = int'(network_busy);
                ts           = int'(timestep);
                break;
            end
        end
        force_done = 1'b0;
        $display("run sim_time=%0d batch=%0d steps=%0d reads=%0d clears=%0d done_cycle=%0d timestep=%0d",
                 st, bt, n_steps, n_rd, n_rst, done_cyc, ts);
    endtask

    int n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts;

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; sim_time = '0; batch_sel = '0;
        cyc(); cyc(); cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (network_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", network_busy); end
        checks++; if ({network_rst, network_step, pat_mem_rd_en} !== 3'b000) begin errors++;
            $display("FAIL reset_strobes: got %b expected 000", {network_rst, network_step, pat_mem_rd_en}); end
        checks++; if (spike_in !== 32'h0) begin errors++; $display("FAIL reset_spike_in: got %h expected 0", spike_in); end
        checks++; if (timestep !== 32'h0) begin errors++; $display("FAIL reset_timestep: got %0d expected 0", timestep); end
        checks++; if (pat_mem_addr !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", pat_mem_addr); end
        // start held through reset counts as an edge once reset releases (sim_time = 0 here)
        rst = 1'b0;
        cyc();
        checks++; if (network_busy !== 1'b1) begin errors++; $display("FAIL reset_release_busy: got %0b expected 1", network_busy); end
        cyc();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_release_done: got %0b expected 1", done); end
        $display("reset test complete");
    endtask

    task automatic test_basic();
        run_seq(3, 5, 40, 0, 0, 0, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (n_steps != 3) begin errors++; $display("FAIL basic_steps: got %0d expected 3", n_steps); end
        checks++; if (n_rd != 3) begin errors++; $display("FAIL basic_reads: got %0d expected 3", n_rd); end
        checks++; if (n_rst != 1) begin errors++; $display("FAIL basic_clears: got %0d expected 1", n_rst); end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL basic_addr: got %0d bad addresses expected 0", addr_bad); end
        checks++; if (spike_bad != 0) begin errors++; $display("FAIL basic_spike_in: got %0d bad patterns expected 0", spike_bad); end
        checks++; if (done_cyc != 15) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 15", done_cyc); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL basic_busy_at_done: got %0d expected 0", busy_at_done); end
        checks++; if (ts != 3) begin errors++; $display("FAIL basic_timestep: got %0d expected 3", ts); end
    endtask

    task automatic test_zero_time();
        run_seq(0, 7, 10, 0, 0, 0, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (n_steps != 0) begin errors++; $display("FAIL zero_steps: got %0d expected 0", n_steps); end
        checks++; if (n_rst != 0) begin errors++; $display("FAIL zero_clears: got %0d expected 0", n_rst); end
    endtask

    task automatic test_wrap();
        run_seq(260, 0, 1200, 0, 0, 0, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (n_steps != 260) begin errors++; $display("FAIL wrap_steps: got %0d expected 260", n_steps); end
        checks++; if (wrapped != 1) begin errors++; $display("FAIL wrap_seen: got %0d expected 1", wrapped); end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL wrap_addr: got %0d bad addresses expected 0", addr_bad); end
        checks++; if (spike_bad != 0) begin errors++; $display("FAIL wrap_spike_in: got %0d bad patterns expected 0", spike_bad); end
        checks++; if (done_cyc != 1043) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 1043", done_cyc); end
        checks++; if (ts != 260) begin errors++; $display("FAIL wrap_timestep: got %0d expected 260", ts); end
    endtask

    task automatic test_abort();
        int steps = 0;
        int step2_cyc = -1;
        int aborted = 0;
        start = 1'b0; abort = 1'b0;
        cyc();
        sim_time = 10; batch_sel = 6'd1; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            start = 1'b0;
            if (network_step) begin
                steps++;
                if (steps == 2) step2_cyc = c;
            end
            if (step2_cyc > 0 && c == step2_cyc + 1) begin
                checks++; if (network_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_in_wait: got %0b expected 1", network_busy); end
                abort = 1'b1;
            end
            if (step2_cyc > 0 && c == step2_cyc + 2) begin
                aborted = 1;
                checks++; if (network_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", network_busy); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
                break;
            end
        end
        abort = 1'b0;
        $display("abort after step pulses=%0d", steps);
        checks++; if (aborted != 1) begin errors++; $display("FAIL abort_reached: got %0d expected 1", aborted); end
        checks++; if (steps != 2) begin errors++; $display("FAIL abort_steps: got %0d expected 2", steps); end
        run_seq(2, 1, 30, 0, 0, 0, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL abort_rerun_done_cycle: got %0d expected 11", done_cyc); end
        checks++; if (n_steps != 2) begin errors++; $display("FAIL abort_rerun_steps: got %0d expected 2", n_steps); end
    endtask

    task automatic test_hold_start();
        int busy_cnt = 0;
        int second_done = -1;
        run_seq(3, 5, 40, 1, 1, 0, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (done_cyc != 15) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 15", done_cyc); end
        checks++; if (n_steps != 3) begin errors++; $display("FAIL hold_steps: got %0d expected 3", n_steps); end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL hold_latched_batch: got %0d bad addresses expected 0", addr_bad); end
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (network_busy) busy_cnt++;
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL hold_retrigger: got %0d busy cycles expected 0", busy_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done_sticky: got %0b expected 1", done); end
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done_cleared: got %0b expected 0", done); end
        checks++; if (network_busy !== 1'b1) begin errors++; $display("FAIL hold_second_busy: got %0b expected 1", network_busy); end
        // sim_time was changed to 7 mid-run, so the second run latches 7: done at 4*7+3
        for (int c = 2; c <= 60; c++) begin
            cyc();
            if (done) begin second_done = c; break; end
        end
        start = 1'b0;
        $display("second run done_cycle=%0d", second_done);
        checks++; if (second_done != 31) begin errors++; $display("FAIL hold_second_done_cycle: got %0d expected 31", second_done); end
    endtask

    task automatic test_spurious_and_reset();
        int strobes = 0;
        run_seq(3, 2, 40, 0, 0, 1, n_steps, n_rd, n_rst, done_cyc, busy_at_done, addr_bad, spike_bad, wrapped, ts);
        checks++; if (n_steps != 3) begin errors++; $display("FAIL spur_steps: got %0d expected 3", n_steps); end
        checks++; if (done_cyc != 15) begin errors++; $display("FAIL spur_done_cycle: got %0d expected 15", done_cyc); end
        checks++; if (ts != 3) begin errors++; $display("FAIL spur_timestep: got %0d expected 3", ts); end
        start = 1'b0;
        cyc();
        sim_time = 5; batch_sel = 6'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
        end
        rst = 1'b1;
        cyc();
        checks++; if ({network_busy, done, network_rst, network_step, pat_mem_rd_en} !== 5'b00000) begin errors++;
            $display("FAIL midrun_reset_flags: got %b expected 00000", {network_busy, done, network_rst, network_step, pat_mem_rd_en}); end
        checks++; if (spike_in !== 32'h0) begin errors++; $display("FAIL midrun_reset_spike_in: got %h expected 0", spike_in); end
        checks++; if (timestep !== 32'h0) begin errors++; $display("FAIL midrun_reset_timestep: got %0d expected 0", timestep); end
        checks++; if (pat_mem_addr !== 14'h0) begin errors++; $display("FAIL midrun_reset_addr: got %h expected 0", pat_mem_addr); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (network_busy || network_rst || network_step || pat_mem_rd_en) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL post_reset_activity: got %0d active cycles expected 0", strobes); end
        $display("reset mid-run complete");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_time();
        test_wrap();
        test_abort();
        test_hold_start();
        test_spurious_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
